hilo_issue_ctrl: RTL and testbench

Decode-side companion to the E-stage HILO multiply/divide unit. It decides when HILO ops are issued and when the pipeline must stall. It keeps a shadow copy of the unit's busy/cycle state, stalls any D-stage instruction that touches HI/LO while an op is being issued or is in flight, and pulses when a result lands. It also flags any divergence between the shadow state and the unit's HILO_busy, and keeps stall/issue statistics for the hazard unit and the testbench.

---
 rtl/hilo_issue_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hilo_issue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_issue_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_issue_ctrl
//
// Decode-side companion to the E-stage HILO multiply/divide unit. It tracks a
// shadow copy of the unit's busy/cycle state and decides when a D-stage
// instruction that touches HI/LO has to stall. It pulses when a mult/div
// result lands, flags any divergence from the unit's own busy output, and
// keeps stall/issue statistics.
//
// Parameters:
//   MULT_CYC     busy cycles for mult/multu (must match the HILO unit)
//   DIV_CYC      busy cycles for div/divu   (must match the HILO unit)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   D_HILO_Op    in   [3:0] HILO op code of the instruction in D (0 = none)
//   E_HILO_Op    in   [3:0] HILO op code presented to the unit this cycle
//   HILO_busy    in   busy output of the HILO unit
//   stall        out  stall D/F, freeze D, bubble into E (combinational)
//   shadow_busy  out  registered shadow of the unit's busy state
//   remaining    out  [3:0] busy cycles left including current; 0 when idle
//   result_ready out  one-cycle pulse: HI/LO just updated by mult/div
//   mismatch     out  sticky protocol/shadow error flag
//   stall_count  out  [31:0] cycles with stall=1, saturating
//   md_count     out  [15:0] mult/div ops accepted, wrapping
//
// Op codes: 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
// Codes 0 and 9..15 are non-HILO and ignored.
// -----------------------------------------------------------------------------
module hilo_issue_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_HILO_Op,
  input  logic [3:0]  E_HILO_Op,
  input  logic        HILO_busy,
  output logic        stall,
  output logic        shadow_busy,
  output logic [3:0]  remaining,
  output logic        result_ready,
  output logic        mismatch,
  output logic [31:0] stall_count,
  output logic [15:0] md_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Any instruction that reads or writes HI/LO.
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  // Multi-cycle ops that occupy the unit (mult/multu/div/divu).
  function automatic logic is_md_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  // Busy length the unit will report for a given multi-cycle op.
  function automatic logic [3:0] busy_cycles(input logic [3:0] op);
    logic [3:0] cyc;
    case (op)
      4'd1, 4'd2: cyc = 4'(MULT_CYC);
      4'd3, 4'd4: cyc = 4'(DIV_CYC);
      default:    cyc = 4'd0;
    endcase
    return cyc;
  endfunction

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        shadow_busy_r;
  logic [3:0]  remaining_r;
  logic        result_ready_r;
  logic        mismatch_r;
  logic [31:0] stall_count_r;
  logic [15:0] md_count_r;

  logic        use_d_s;
  logic        md_op_s;
  logic        start_s;
  logic [3:0]  load_s;

  // Decode of the D and E op codes; an E mult/div is only accepted outside BUSY.
  assign use_d_s = is_hilo_op(D_HILO_Op);
  assign md_op_s = is_md_op(E_HILO_Op);
  assign start_s = md_op_s && (state_r != ST_BUSY);
  assign load_s  = busy_cycles(E_HILO_Op);

  // Stall is evaluated against the current state: an op issuing this cycle
  // already blocks a HI/LO reader sitting behind it in D.
  assign stall = use_d_s && (start_s || HILO_busy || shadow_busy_r);

  assign shadow_busy  = shadow_busy_r;
  assign remaining    = remaining_r;
  assign result_ready = result_ready_r;
  assign mismatch     = mismatch_r;
  assign stall_count  = stall_count_r;
  assign md_count     = md_count_r;

  // Issue FSM: shadows the unit's busy window; outputs are registered
  // alongside the state so they always agree with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 4'd0;
      shadow_busy_r  <= 1'b0;
      remaining_r    <= 4'd0;
      result_ready_r <= 1'b0;
    end else begin
      case (state_r)
        // DONE accepts a new op exactly like IDLE, so back-to-back ops lose
        // no cycle; the DONE pulse belongs to the previous op.
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            state_r        <= ST_BUSY;
            cnt_r          <= load_s;
            shadow_busy_r  <= 1'b1;
            remaining_r    <= load_s;
            result_ready_r <= 1'b0;
          end else begin
            state_r        <= ST_IDLE;
            cnt_r          <= 4'd0;
            shadow_busy_r  <= 1'b0;
            remaining_r    <= 4'd0;
            result_ready_r <= 1'b0;
          end
        end
        // An E mult/div seen here is an illegal issue; it is flagged by the
        // error logic and otherwise ignored (no reload).
        ST_BUSY: begin
          if (cnt_r <= 4'd1) begin
            state_r        <= ST_DONE;
            cnt_r          <= 4'd0;
            shadow_busy_r  <= 1'b0;
            remaining_r    <= 4'd0;
            result_ready_r <= 1'b1;
          end else begin
            state_r        <= ST_BUSY;
            cnt_r          <= cnt_r - 4'd1;
            shadow_busy_r  <= 1'b1;
            remaining_r    <= cnt_r - 4'd1;
            result_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          cnt_r          <= 4'd0;
          shadow_busy_r  <= 1'b0;
          remaining_r    <= 4'd0;
          result_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: shadow disagrees with the unit, or an issue slipped past
  // the stall while the unit was still busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch_r <= 1'b0;
    end else if ((HILO_busy != shadow_busy_r) || (md_op_s && (state_r == ST_BUSY))) begin
      mismatch_r <= 1'b1;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count_r <= 32'd0;
    end else if (stall && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  // Wrapping count of accepted mult/div ops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      md_count_r <= 16'd0;
    end else if (start_s) begin
      md_count_r <= md_count_r + 16'd1;
    end else begin
      md_count_r <= md_count_r;
    end
  end

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_issue_ctrl
//
// Directed-vector bench for hilo_issue_ctrl. The driver applies one vector per
// cycle on the falling edge and pushes the hand-computed expected outputs for
// that cycle into a queue; an independent monitor pops each entry shortly
// afterwards (still before the rising edge) and compares against the DUT.
// An expected value of -1 means "don't check".
// -----------------------------------------------------------------------------
module tb_hilo_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_HILO_Op;
  logic [3:0]  E_HILO_Op;
  logic        HILO_busy;
  logic        stall;
  logic        shadow_busy;
  logic [3:0]  remaining;
  logic        result_ready;
  logic        mismatch;
  logic [31:0] stall_count;
  logic [15:0] md_count;

  hilo_issue_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .D_HILO_Op    (D_HILO_Op),
    .E_HILO_Op    (E_HILO_Op),
    .HILO_busy    (HILO_busy),
    .stall        (stall),
    .shadow_busy  (shadow_busy),
    .remaining    (remaining),
    .result_ready (result_ready),
    .mismatch     (mismatch),
    .stall_count  (stall_count),
    .md_count     (md_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string  ph;
    int     cyc;
    longint st;
    longint sb;
    longint rem;
    longint rr;
    longint mm;
    longint sc;
    longint md;
  } exp_t;

  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string phase = "init";

  task automatic chk(input string ph, input int c, input string nm,
                     input longint act, input longint want);
    if (want >= 0) begin
      total++;
      if (act != want) begin
        bad++;
        $display("FAIL %s cyc%0d %s: got %0h want %0h", ph, c, nm, act, want);
      end
    end
  endtask

  // One cycle of stimulus plus its expected outputs (observed before the edge).
  task automatic step(input int d, input int e, input int b,
                      input longint st, input longint sb, input longint rem,
                      input longint rr, input longint mm, input longint sc,
                      input longint md);
    exp_t x;
    @(negedge clk);
    reset     = 1'b1;
    D_HILO_Op = 4'(d);
    E_HILO_Op = 4'(e);
    HILO_busy = b[0];
    #1;
    x.ph = phase; x.cyc = cyc;
    x.st = st; x.sb = sb; x.rem = rem; x.rr = rr;
    x.mm = mm; x.sc = sc; x.md = md;
    exp_q.push_back(x);
    cyc++;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk(x.ph, x.cyc, "stall",        longint'(stall),        x.st);
        chk(x.ph, x.cyc, "shadow_busy",  longint'(shadow_busy),  x.sb);
        chk(x.ph, x.cyc, "remaining",    longint'(remaining),    x.rem);
        chk(x.ph, x.cyc, "result_ready", longint'(result_ready), x.rr);
        chk(x.ph, x.cyc, "mismatch",     longint'(mismatch),     x.mm);
        chk(x.ph, x.cyc, "stall_count",  longint'(stall_count),  x.sc);
        chk(x.ph, x.cyc, "md_count",     longint'(md_count),     x.md);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    D_HILO_Op = 4'd0;
    E_HILO_Op = 4'd0;
    HILO_busy = 1'b0;
    repeat (2) @(posedge clk);

    phase = "reset";
    step(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    // mult with mfhi held in D: 6 stalled cycles, pulse on the 7th
    phase = "mult";
    step(5, 1, 0,  1, 0, 0, 0, 0, 0, 0);
    for (int i = 5; i >= 1; i--) step(5, 0, 1,  1, 1, i, 0, 0, 6 - i, 1);
    step(5, 0, 0,  0, 0, 0, 1, 0, 6, 1);

    // div with no HILO reader in D: never stalls
    phase = "div";
    step(0, 3, 0,  0, 0, 0, 0, 0, 6, 1);
    for (int i = 10; i >= 1; i--) step(0, 0, 1,  0, 1, i, 0, 0, 6, 2);
    step(0, 0, 0,  0, 0, 0, 1, 0, 6, 2);

    // mthi/mtlo in E change nothing
    phase = "mthi_mtlo";
    step(0, 7, 0,  0, 0, 0, 0, 0, 6, 2);
    step(0, 8, 0,  0, 0, 0, 0, 0, 6, 2);

    // multu (D code 9 is not a HILO op), then divu issued in the DONE cycle
    phase = "b2b";
    step(9, 2, 0,  0, 0, 0, 0, 0, 6, 2);
    for (int i = 5; i >= 1; i--) step(0, 0, 1,  0, 1, i, 0, 0, 6, 3);
    step(6, 4, 0,  1, 0, 0, 1, 0, 6, 3);
    for (int i = 10; i >= 1; i--) step(0, 0, 1,  0, 1, i, 0, 0, 7, 4);
    step(0, 0, 0,  0, 0, 0, 1, 0, 7, 4);

    // unit drops busy one cycle early -> sticky mismatch
    phase = "early_drop";
    step(0, 1, 0,  0, 0, 0, 0, 0, 7, 4);
    for (int i = 5; i >= 2; i--) step(0, 0, 1,  0, 1, i, 0, 0, 7, 5);
    step(0, 0, 0,  0, 1, 1, 0, 0, 7, 5);
    step(0, 0, 0,  0, 0, 0, 1, 1, 7, 5);
    step(0, 0, 0,  0, 0, 0, 0, 1, 7, 5);

    // reset while a div shows remaining=4
    phase = "reset_mid";
    step(0, 3, 0,  0, 0, 0, 0, 1, 7, 5);
    for (int i = 10; i >= 4; i--) step(0, 0, 1,  0, 1, i, 0, 1, 7, 6);
    reset = 1'b0;
    step(0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

    // mult after reset; multu issued while busy is flagged, not reloaded
    phase = "issue_busy";
    step(0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1,  0, 1, 5, 0, 0, 0, 1);
    step(0, 2, 1,  0, 1, 4, 0, 0, 0, 1);
    for (int i = 3; i >= 1; i--) step(0, 0, 1,  0, 1, i, 0, 1, 0, 1);
    step(0, 0, 0,  0, 0, 0, 1, 1, 0, 1);

    // counter limits: stall_count saturates, md_count wraps
    phase = "limits";
    @(negedge clk);
    force dut.stall_count_r = 32'hFFFF_FFFE;
    force dut.md_count_r    = 16'hFFFF;
    #1;
    release dut.stall_count_r;
    release dut.md_count_r;
    step(5, 1, 0,  1, 0, 0, 0, 1, 32'hFFFF_FFFE, 16'hFFFF);
    for (int i = 5; i >= 3; i--) step(5, 0, 1,  1, 1, i, 0, 1, 32'hFFFF_FFFF, 0);
    for (int i = 2; i >= 1; i--) step(0, 0, 1,  0, 1, i, 0, 1, 32'hFFFF_FFFF, 0);
    step(0, 0, 0,  0, 0, 0, 1, 1, 32'hFFFF_FFFF, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL monitor_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
